shift_sequencer: RTL

- Row-by-row controller for the 33-group (1056-bit) circular shifter in the fault-correction path.
- For each row it accepts one per-row command (direction, step, bypass) and drives the shifter's control pins. It detects the shifter's completion pulse and emits a one-cycle capture strobe for the downstream row register, then advances.
- Sits between the correction FSM, which supplies commands, and the circular shifter. It never touches the 1056-bit datapath.

---
 rtl/shift_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Row-by-row controller for the 1056-bit circular shifter: fetches one command per row,
// drives the shifter control pins, waits for a fresh completion and strobes row capture.
module shift_sequencer #(
  parameter int ROWS       = 33,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 2,
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [5:0]       cmd_step,
  input  logic             cmd_bypass,
  output logic             shift_enable,
  output logic             direct_connection,
  output logic             shift_direction,
  output logic [5:0]       step_size,
  input  logic             shift_ready,
  output logic [IDX_W-1:0] row_idx,
  output logic             row_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [1:0]       ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]       ERR_STEP    = 2'd2;

  state_t           state;
  logic             bypass_q;
  logic             seen_low;
  logic [7:0]       to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // A bypassed row skips the shifter entirely, so its step field is don't-care.
  function automatic logic step_illegal(input logic [5:0] step, input logic bypass);
    return !bypass && (step > 6'd32);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      bypass_q          <= 1'b0;
      seen_low          <= 1'b0;
      to_cnt            <= '0;
      gap_cnt           <= '0;
      cmd_ready         <= 1'b0;
      shift_enable      <= 1'b0;
      direct_connection <= 1'b0;
      shift_direction   <= 1'b0;
      step_size         <= '0;
      row_idx           <= '0;
      row_done          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      err_code          <= '0;
    end else if (abort) begin
      state             <= S_IDLE;
      cmd_ready         <= 1'b0;
      shift_enable      <= 1'b0;
      direct_connection <= 1'b0;
      row_done          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      err_code          <= '0;
    end else begin
      row_done <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            row_idx   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          if (cmd_valid) begin
            shift_direction <= cmd_dir;
            step_size       <= cmd_step;
            bypass_q        <= cmd_bypass;
            cmd_ready       <= 1'b0;
            if (step_illegal(cmd_step, cmd_bypass)) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_STEP;
              busy     <= 1'b0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          shift_enable      <= !bypass_q;
          direct_connection <= bypass_q;
          seen_low          <= 1'b0;
          to_cnt            <= '0;
          state             <= S_WAIT;
        end
        S_WAIT: begin
          // A ready level still high from the previous row only counts after a low sample.
          to_cnt <= to_cnt + 8'd1;
          if (!shift_ready) seen_low <= 1'b1;
          if (shift_ready && seen_low) begin
            row_done          <= 1'b1;
            shift_enable      <= 1'b0;
            direct_connection <= 1'b0;
            gap_cnt           <= '0;
            state             <= S_GAP;
          end else if (to_cnt == TO_LAST) begin
            shift_enable      <= 1'b0;
            direct_connection <= 1'b0;
            err               <= 1'b1;
            err_code          <= ERR_TIMEOUT;
            busy              <= 1'b0;
            state             <= S_ERR;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (row_idx == LAST_ROW) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              row_idx   <= row_idx + IDX_W'(1);
              cmd_ready <= 1'b1;
              state     <= S_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          if (start) begin
            err       <= 1'b0;
            err_code  <= '0;
            row_idx   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
